// File: rtl/matriz_pkg.sv
// Shared definitions for the matrix loader and the determinant ALU:
// element geometry, size codes, FSM encoding and element-count helper.
package matriz_pkg;

  localparam int ELEM_W   = 8;
  localparam int MAX_N    = 5;
  localparam int MATRIZ_W = MAX_N * MAX_N * ELEM_W;
  localparam int CNT_W    = 5;

  localparam logic [1:0] TAM_2X2 = 2'b00;
  localparam logic [1:0] TAM_3X3 = 2'b01;
  localparam logic [1:0] TAM_4X4 = 2'b10;
  localparam logic [1:0] TAM_5X5 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_HOLD = 2'b10
  } estado_t;

  function automatic logic [CNT_W-1:0] num_elementos(input logic [1:0] code);
    logic [CNT_W-1:0] n;
    case (code)
      TAM_2X2: n = 5'd4;
      TAM_3X3: n = 5'd9;
      TAM_4X4: n = 5'd16;
      TAM_5X5: n = 5'd25;
      default: n = 5'd25;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/contador_elementos.sv
// Element counter for the loader: clear, increment and terminal-count
// detection against the number of elements implied by the size code.
module contador_elementos
  import matriz_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [1:0]       tamanho,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  // Count register; clear wins over increment so it never passes 24
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 5'd0;
    end else if (clr) begin
      count <= 5'd0;
    end else if (inc) begin
      count <= count + 5'd1;
    end else begin
      count <= count;
    end
  end

  assign terminal = (count == (num_elementos(tamanho) - 5'd1));

endmodule

// File: rtl/carregador_matriz.sv
// Matrix loader: packs row-major signed elements into the 200-bit matrix
// word and offers it to the determinant stage under a valid/ack handshake.
module carregador_matriz
  import matriz_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          tamanho_in,
  input  logic                abort,
  input  logic [ELEM_W-1:0]   elem_in,
  input  logic                elem_valid,
  output logic                elem_ready,
  output logic [MATRIZ_W-1:0] matriz,
  output logic [1:0]          tamanho_matriz,
  output logic                matriz_valid,
  input  logic                matriz_ack
);

  estado_t          state;
  logic [CNT_W-1:0] count;
  logic             terminal;
  logic             cnt_clr;
  logic             cnt_inc;

  // Counter control: clear on start, abort or the last transfer
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = start;
      end
      ST_LOAD: begin
        if (abort) begin
          cnt_clr = 1'b1;
        end else if (elem_valid) begin
          cnt_clr = terminal;
          cnt_inc = !terminal;
        end else begin
          cnt_inc = 1'b0;
        end
      end
      default: begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
      end
    endcase
  end

  contador_elementos u_contador (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .tamanho  (tamanho_matriz),
    .count    (count),
    .terminal (terminal)
  );

  // Load FSM with registered handshake outputs and slot write-decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      matriz         <= '0;
      tamanho_matriz <= 2'b00;
      elem_ready     <= 1'b0;
      matriz_valid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_LOAD;
            tamanho_matriz <= tamanho_in;
            matriz         <= '0;
            elem_ready     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state      <= ST_IDLE;
            matriz     <= '0;
            elem_ready <= 1'b0;
          end else if (elem_valid) begin
            for (int k = 0; k < MAX_N * MAX_N; k++) begin
              if (count == CNT_W'(k)) begin
                matriz[k*ELEM_W +: ELEM_W] <= elem_in;
              end
            end
            if (terminal) begin
              state        <= ST_HOLD;
              elem_ready   <= 1'b0;
              matriz_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // matriz stays intact after the ack until the next start
          if (matriz_ack) begin
            state        <= ST_IDLE;
            matriz_valid <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          elem_ready   <= 1'b0;
          matriz_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_matriz.sv
// Self-checking bench for carregador_matriz: vector table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_carregador_matriz;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   tamanho_in;
  logic         abort;
  logic [7:0]   elem_in;
  logic         elem_valid;
  logic         elem_ready;
  logic [199:0] matriz;
  logic [1:0]   tamanho_matriz;
  logic         matriz_valid;
  logic         matriz_ack;

  int n_checks = 0;
  int n_errors = 0;

  carregador_matriz dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .tamanho_in     (tamanho_in),
    .abort          (abort),
    .elem_in        (elem_in),
    .elem_valid     (elem_valid),
    .elem_ready     (elem_ready),
    .matriz         (matriz),
    .tamanho_matriz (tamanho_matriz),
    .matriz_valid   (matriz_valid),
    .matriz_ack     (matriz_ack)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = waiting, 1 = collecting, 2 = offering
  int         m_mode;
  int         m_cnt;
  int         m_n;
  logic [1:0] m_tam;
  logic [7:0] m_bytes [25];
  int         dut_acc;

  function automatic logic [199:0] model_matrix();
    logic [199:0] v = '0;
    for (int k = 0; k < 25; k++) v[8*k +: 8] = m_bytes[k];
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_n = 2; m_tam = 2'b00;
    for (int k = 0; k < 25; k++) m_bytes[k] = 8'h00;
  endtask

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("elem_ready", {199'd0, elem_ready}, {199'd0, (m_mode == 1)});
    chk("matriz_valid", {199'd0, matriz_valid}, {199'd0, (m_mode == 2)});
    chk("tamanho_matriz", {198'd0, tamanho_matriz}, {198'd0, m_tam});
    chk("matriz", matriz, model_matrix());
  endtask

  // One clock: drive inputs, count handshakes, advance model, compare
  task automatic step(input logic st, input logic [1:0] tm, input logic ab,
                      input logic ev, input logic [7:0] el, input logic ak);
    start = st; tamanho_in = tm; abort = ab;
    elem_valid = ev; elem_in = el; matriz_ack = ak;
    if (elem_ready && ev && !ab) dut_acc++;
    @(posedge clk);
    case (m_mode)
      0: if (st) begin
        m_mode = 1; m_cnt = 0; m_tam = tm; m_n = int'(tm) + 2;
        for (int k = 0; k < 25; k++) m_bytes[k] = 8'h00;
      end
      1: if (ab) begin
        m_mode = 0; m_cnt = 0;
        for (int k = 0; k < 25; k++) m_bytes[k] = 8'h00;
      end else if (ev) begin
        m_bytes[m_cnt] = el;
        m_cnt++;
        if (m_cnt == m_n * m_n) m_mode = 2;
      end
      2: if (ak) m_mode = 0;
      default: m_mode = 0;
    endcase
    #1;
    check_model();
  endtask

  typedef struct {
    logic       st;
    logic [1:0] tm;
    logic       ab;
    logic       ev;
    logic [7:0] el;
    logic       ak;
    logic       exp_ready;
    logic       exp_valid;
  } vec_t;

  vec_t vecs [8];
  logic [199:0] exp5;

  initial begin
    rst_n = 1'b0; start = 1'b0; tamanho_in = 2'b00; abort = 1'b0;
    elem_in = 8'h00; elem_valid = 1'b0; matriz_ack = 1'b0;
    dut_acc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_model();

    // 2x2 load as a vector table; start in HOLD must be ignored
    vecs[0] = '{1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 2'b00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 2'b00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 2'b00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 2'b00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 2'b11, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].st, vecs[i].tm, vecs[i].ab, vecs[i].ev, vecs[i].el, vecs[i].ak);
      chk($sformatf("vec%0d_ready", i), {199'd0, elem_ready}, {199'd0, vecs[i].exp_ready});
      chk($sformatf("vec%0d_valid", i), {199'd0, matriz_valid}, {199'd0, vecs[i].exp_valid});
    end
    chk("2x2_low", {168'd0, matriz[31:0]}, {168'd0, 32'h04020103});
    chk("2x2_high", {32'd0, matriz[199:32]}, 200'd0);

    // 3x3 with bubbles; start with another size during LOAD is ignored
    step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    dut_acc = 0;
    for (int e = 1; e <= 9; e++) begin
      step(1'b1, 2'b11, 1'b0, 1'b0, 8'hEE, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b1, 8'(e), 1'b0);
    end
    chk("3x3_data", {128'd0, matriz[71:0]}, {128'd0, 72'h090807060504030201});
    chk("3x3_accepts", 200'(dut_acc), 200'd9);
    chk("3x3_tam", {198'd0, tamanho_matriz}, {198'd0, 2'b01});
    // ack together with start: back to IDLE only
    step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("ack_start_no_load", {199'd0, elem_ready}, 200'd0);

    // 5x5 full load, held until ack, retained after it
    exp5 = '0;
    for (int k = 0; k < 25; k++) exp5[8*k +: 8] = 8'h80 + 8'(k);
    step(1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 25; k++) step(1'b0, 2'b11, 1'b0, 1'b1, 8'h80 + 8'(k), 1'b0);
    chk("5x5_full", matriz, exp5);
    repeat (3) step(1'b0, 2'b00, 1'b1, 1'b1, 8'h11, 1'b0);
    chk("5x5_held_valid", {199'd0, matriz_valid}, {199'd0, 1'b1});
    step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (3) step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("5x5_retained", matriz, exp5);

    // Abort after 7 elements of a 4x4 with an element offered
    step(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 7; k++) step(1'b0, 2'b10, 1'b0, 1'b1, 8'h10 + 8'(k), 1'b0);
    step(1'b0, 2'b10, 1'b1, 1'b1, 8'h77, 1'b0);
    chk("abort_clear", matriz, 200'd0);
    chk("abort_idle", {199'd0, elem_ready}, 200'd0);
    // New 2x2 with ack held through the load: no effect
    step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 2'b00, 1'b0, 1'b1, 8'h05 + 8'(k), 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("reload_2x2", matriz, {168'd0, 32'h08070605});
    chk("reload_valid", {199'd0, matriz_valid}, {199'd0, 1'b1});
    step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a 4x4 load
    step(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 2'b10, 1'b0, 1'b1, 8'hA0 + 8'(k), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_matriz", matriz, 200'd0);
    chk("arst_ready", {199'd0, elem_ready}, 200'd0);
    chk("arst_valid", {199'd0, matriz_valid}, 200'd0);
    chk("arst_tam", {198'd0, tamanho_matriz}, 200'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 2'b00, 1'b0, 1'b1, 8'h42, 1'b0);
    chk("arst_after_idle", {199'd0, elem_ready}, 200'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7),
           8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/carregador_matriz.md
Name: carregador_matriz

Overview:
Upstream stage of the determinant ALU. Accepts signed 8-bit matrix elements one per handshake, row-major, from the host/bus interface. Packs them densely into the 200-bit matrix word and presents that word, with its size code, to the determinant stage under a valid/ack handshake. Unused high element slots read as zero.

Parameters:
ELEM_W, 8, width of one signed element in bits
MAX_N, 5, largest supported matrix dimension; output width = MAX_N*MAX_N*ELEM_W = 200

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new load; sampled only in IDLE
tamanho_in  input  2  size code: 00=2x2, 01=3x3, 10=4x4, 11=5x5; sampled with start
abort  input  1  discard the load in progress; effective only in LOAD
elem_in  input  8  signed element, row-major order
elem_valid  input  1  elem_in holds a valid element
elem_ready  output  1  block accepts an element this cycle
matriz  output  200  packed matrix; element k (k = row*N + col) at bits [8k+7:8k]
tamanho_matriz  output  2  size code latched at start
matriz_valid  output  1  matriz/tamanho_matriz complete and stable
matriz_ack  input  1  consumer has taken the matrix

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, matriz=0, tamanho_matriz=00, matriz_valid=0, elem_ready=0.
- FSM states: IDLE, LOAD, HOLD. elem_ready = (state==LOAD). matriz_valid = (state==HOLD). Both are decoded from registered state, so there is no input-to-output combinational path.
- IDLE:
  - start=1: latch tamanho_in into tamanho_matriz, clear matriz to 0, count=0, go to LOAD.
  - Otherwise hold. matriz keeps its last value.
- LOAD:
  - Transfer occurs when elem_valid && elem_ready at a clock edge. The transfer writes elem_in to slot count and increments count.
  - Transfer with count == N*N-1 (N=2..5 from the latched code): go to HOLD. matriz_valid is high in the cycle after the last transfer, so latency is 1 clock from the last accept to valid.
  - elem_valid low: hold, no write. Any number of bubble cycles is allowed.
  - abort=1: go to IDLE, count=0, matriz cleared to 0, and any element offered that cycle is dropped. abort has priority over a transfer in the same cycle.
  - start and tamanho_in changes are ignored during LOAD.
- HOLD:
  - matriz and tamanho_matriz are frozen. elem_ready=0.
  - matriz_ack=1: go to IDLE, so matriz_valid falls the next cycle.
  - start asserted in HOLD is ignored even if it coincides with matriz_ack; it must be presented again in IDLE.
  - abort is ignored in HOLD.
- Matrix retention after the ack: matriz keeps its content until the next start, so the clocked determinant stage may sample it after the handshake.
- Counter: 5 bits, maximum value 24. It never wraps, because the LOAD→HOLD transition occurs at the terminal count.
- Slot writes: index = count*8, decoded by a case/loop over 25 slots. Slots ≥ N*N stay 0 for the whole transaction.
- Elements are stored bit-exact, with no sign extension or arithmetic.
- Reset mid-LOAD or mid-HOLD: immediate return to reset values. The partial matrix is lost.

Decomposition:
- Package matriz_pkg holds:
  - ELEM_W and MAX_N.
  - Size-code constants: TAM_2X2=2'b00, TAM_3X3=2'b01, TAM_4X4=2'b10, TAM_5X5=2'b11.
  - FSM state encoding.
  - Function num_elementos(code) returning 4/9/16/25.
- The determinant ALU shares these size codes.
- One natural sub-module: contador_elementos, holding the count register, increment/clear, and terminal-count compare against num_elementos(tamanho). The FSM and slot write-decode stay in the top.

Test Plan:
- 2x2 load: start with tamanho_in=00, then elements 3,1,2,4 back-to-back → matriz_valid high 1 cycle after the 4th accept; matriz[31:0]=32'h04020103; matriz[199:32]=0; elem_ready low in HOLD.
- 3x3 with bubbles: tamanho_in=01, elements 1..9 with elem_valid toggled every other cycle → matriz[71:0]=72'h090807060504030201; exactly 9 accepts; tamanho_matriz=01.
- 5x5 full: tamanho_in=11, elements 0x80,0x81,...,0x98 → all 200 bits filled with element k at byte k (byte 24 = 0x98); no wrap; valid held until matriz_ack; matriz unchanged 3 cycles after the ack.
- Abort: tamanho_in=10, 7 elements accepted, then abort=1 together with elem_valid=1 → IDLE next cycle, matriz=0, the 8th element is not written; a new 2x2 load then completes correctly.
- Handshake corners: start held high in HOLD and LOAD → ignored; ack and start in the same cycle → return to IDLE only, no new load; matriz_ack held 5 cycles before completion → no effect.
- Async reset: assert rst_n=0 mid-edge during LOAD of a 4x4 → outputs zero immediately without a clock edge; after release, the block is in IDLE with elem_ready=0.
